// File: rtl/sext_accumulator.sv
// -----------------------------------------------------------------------------
// sext_accumulator
//   Accepts signed SAMPLE_W-bit samples over a valid/ready handshake, sign-extends
//   each one to OUT_W bits and sums every COUNT accepted samples into one frame
//   total. The total is held on a valid/ready output port until it is taken.
//
//   Optional feature macro: SATURATE_EN
//     defined   : every add clamps to the signed OUT_W range and a sticky
//                 sat_seen flag records that a clamp happened.
//     undefined : adds wrap modulo 2^OUT_W and sat_seen is tied low.
//
//   in_ready is a registered function of the FSM state only, so there is no
//   combinational path from out_ready (or anything else) to in_ready.
// -----------------------------------------------------------------------------
module sext_accumulator #(
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 32,
    parameter int COUNT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_data,
    input  logic                out_ready,
    output logic                sat_seen
);

    // Sample counter is wide enough for the largest frame length (65535).
    localparam int             CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Replicate the sample sign bit into the upper OUT_W-SAMPLE_W bits.
    function automatic logic [OUT_W-1:0] sign_extend(input logic [SAMPLE_W-1:0] s);
        return {{(OUT_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

`ifdef SATURATE_EN
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Signed add with clamping; result is {clamped_flag, clamped_sum}.
    // Overflow only happens when both operands share a sign and the raw sum
    // does not; the clamp direction then follows the operand sign.
    function automatic logic [OUT_W:0] sat_add(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b);
        logic [OUT_W-1:0] raw;
        logic             ovf;
        raw = a + b;
        ovf = (a[OUT_W-1] == b[OUT_W-1]) && (raw[OUT_W-1] != a[OUT_W-1]);
        if (!ovf) begin
            return {1'b0, raw};
        end else if (a[OUT_W-1]) begin
            return {1'b1, SAT_MIN};
        end else begin
            return {1'b1, SAT_MAX};
        end
    endfunction
`endif

    // State and datapath flops
    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               in_ready_q, in_ready_d;

    // Combinational helpers
    logic [OUT_W-1:0]   ext_s;
    logic [OUT_W-1:0]   sum_s;
    logic               accept_s;

`ifdef SATURATE_EN
    logic               sat_seen_q, sat_seen_d;
    logic               clamp_s;
`endif

    // Sign-extend the incoming sample and form the running sum for this cycle.
    always_comb begin
        ext_s    = sign_extend(in_data);
        accept_s = in_valid & in_ready_q;
`ifdef SATURATE_EN
        {clamp_s, sum_s} = sat_add(acc_q, ext_s);
`else
        sum_s = acc_q + ext_s;
`endif
    end

    // Next-state logic for the ACCUM/HOLD frame controller and its datapath.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef SATURATE_EN
        sat_seen_d  = sat_seen_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (flush) begin
                    // A flush discards the partial frame and drops any sample
                    // presented in the same cycle.
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept_s) begin
`ifdef SATURATE_EN
                    sat_seen_d = sat_seen_q | clamp_s;
`endif
                    if (cnt_q == CNT_LAST) begin
                        out_data_d  = sum_s;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = sum_s;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    acc_d = acc_q;
                    cnt_d = cnt_q;
                end
            end
            ST_HOLD: begin
                // flush is deliberately ignored here: the completed total is
                // always delivered.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
        // in_ready follows the state we are about to enter, registered.
        if (state_d == ST_ACCUM) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
    end

    // Register all state; synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
`ifdef SATURATE_EN
            sat_seen_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
`ifdef SATURATE_EN
            sat_seen_q  <= sat_seen_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef SATURATE_EN
    assign sat_seen  = sat_seen_q;
`else
    assign sat_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_sext_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sext_accumulator
//   Directed bench for sext_accumulator. Three instances: the default
//   configuration (COUNT=4, OUT_W=32), a single-sample frame (COUNT=1) and a
//   narrow accumulator (OUT_W=12, COUNT=32) whose expectation depends on
//   whether SATURATE_EN is defined. Expected totals are pushed to per-instance
//   queues when stimulus is driven and popped when a total appears.
// -----------------------------------------------------------------------------
module tb_sext_accumulator;

    logic clk = 1'b0;
    logic reset;

    // Instance A: defaults
    logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, sat_seen_a;
    logic [7:0]  in_data_a;
    logic [31:0] out_data_a;

    // Instance B: COUNT=1
    logic        in_valid_b, in_ready_b, out_valid_b, sat_seen_b;
    logic [7:0]  in_data_b;
    logic [31:0] out_data_b;

    // Instance C: OUT_W=12, COUNT=32
    logic        in_valid_c, in_ready_c, out_valid_c, sat_seen_c;
    logic [7:0]  in_data_c;
    logic [11:0] out_data_c;

    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    logic [31:0] sb_c[$];

    int passed_cnt = 0;
    int total_cnt  = 0;

    always #5 clk = ~clk;

    sext_accumulator #(.SAMPLE_W(8), .OUT_W(32), .COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .flush(flush_a), .out_valid(out_valid_a),
        .out_data(out_data_a), .out_ready(out_ready_a), .sat_seen(sat_seen_a));

    sext_accumulator #(.SAMPLE_W(8), .OUT_W(32), .COUNT(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .flush(1'b0), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_ready(1'b1), .sat_seen(sat_seen_b));

    sext_accumulator #(.SAMPLE_W(8), .OUT_W(12), .COUNT(32)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_data(in_data_c),
        .in_ready(in_ready_c), .flush(1'b0), .out_valid(out_valid_c),
        .out_data(out_data_c), .out_ready(1'b1), .sat_seen(sat_seen_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one sample to instance A and return #1 after the accepting edge.
    task automatic send_a(input logic [7:0] d);
        int g;
        g = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        while (in_ready_a !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) chk("send_a_timeout", 32'(in_ready_a), 32'd1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    // Wait for a total on instance A, compare against the scoreboard, take it.
    task automatic expect_out_a(input string tag);
        int          g;
        logic [31:0] exp;
        g = 0;
        if (sb_a.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_a.size()), 32'd1);
            return;
        end
        exp = sb_a.pop_front();
        while (out_valid_a !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk({tag, "_valid"}, 32'(out_valid_a), 32'd1);
        chk({tag, "_data"}, out_data_a, exp);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 32'(out_valid_a), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid_a = 1'b0; in_data_a = 8'h00; flush_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = 8'h00;
        in_valid_c = 1'b0; in_data_c = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data", out_data_a, 32'h0000_0000);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        chk("rst_sat_seen", 32'(sat_seen_a), 32'd0);

        // Mixed signs: 1 - 1 - 128 + 127 = -1, visible right after 4th accept
        sb_a.push_back(32'hFFFF_FFFF);
        send_a(8'h01); send_a(8'hFF); send_a(8'h80); send_a(8'h7F);
        chk("t1_latency", 32'(out_valid_a), 32'd1);
        expect_out_a("t1");

        // Back-pressure: total held stable, extra samples refused
        out_ready_a = 1'b0;
        sb_a.push_back(32'h0000_0040);
        send_a(8'h10); send_a(8'h10); send_a(8'h10); send_a(8'h10);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(out_valid_a), 32'd1);
            chk("t2_hold_data", out_data_a, 32'h0000_0040);
            chk("t2_hold_in_ready", 32'(in_ready_a), 32'd0);
            in_valid_a = 1'b1;
            in_data_a  = 8'h33;
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        expect_out_a("t2");

        // Next frame proves the refused samples were not counted
        sb_a.push_back(32'h0000_000A);
        send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
        expect_out_a("t2b");

        // Reset in mid-frame discards the partial sum
        sb_a.push_back(32'h0000_0008);
        send_a(8'h05); send_a(8'h05);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t3_rst_out_data", out_data_a, 32'h0000_0000);
        chk("t3_rst_in_ready", 32'(in_ready_a), 32'd1);
        send_a(8'h02); send_a(8'h02); send_a(8'h02); send_a(8'h02);
        expect_out_a("t3");

        // Flush in ACCUM wins over a simultaneous sample
        sb_a.push_back(32'h0000_0004);
        send_a(8'h7F); send_a(8'h7F); send_a(8'h7F);
        flush_a = 1'b1; in_valid_a = 1'b1; in_data_a = 8'h7F;
        @(posedge clk); #1;
        flush_a = 1'b0; in_valid_a = 1'b0;
        send_a(8'h01); send_a(8'h01); send_a(8'h01); send_a(8'h01);
        expect_out_a("t4");

        // Flush in HOLD does not discard the held total
        out_ready_a = 1'b0;
        sb_a.push_back(32'hFFFF_FFFC);
        send_a(8'hFF); send_a(8'hFF); send_a(8'hFF); send_a(8'hFF);
        flush_a = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0;
        expect_out_a("t5");
        chk("a_sat_seen", 32'(sat_seen_a), 32'd0);

        // COUNT=1: each sample is its own frame
        sb_b.push_back(32'hFFFF_FF80);
        in_valid_b = 1'b1; in_data_b = 8'h80;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        chk("t6_valid", 32'(out_valid_b), 32'd1);
        chk("t6_data", out_data_b, sb_b.pop_front());

        // Narrow accumulator: 32 x 127 = 4064 (wraps vs. clamps in 12 bits)
`ifdef SATURATE_EN
        sb_c.push_back(32'h0000_07FF);
`else
        sb_c.push_back(32'h0000_0FE0);
`endif
        in_valid_c = 1'b1; in_data_c = 8'h7F;
        repeat (32) @(posedge clk);
        #1;
        in_valid_c = 1'b0;
        chk("t7_valid", 32'(out_valid_c), 32'd1);
        chk("t7_data", 32'(out_data_c), sb_c.pop_front());
`ifdef SATURATE_EN
        chk("t7_sat_seen", 32'(sat_seen_c), 32'd1);
        @(posedge clk); #1;
        chk("t7_sat_sticky", 32'(sat_seen_c), 32'd1);
`else
        chk("t7_sat_seen", 32'(sat_seen_c), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
